wash_cycle_ctrl: RTL
====================

// Module: wash_cycle_ctrl
// PURPOSE
//  Master sequencer for the washer; consumes the phase-timer expiry pulses and drives the timer's clear/load.
//  Steps fill -> wash -> drain -> rinse-fill -> rinse -> drain -> spin, drives valves/motors/door lock.
//  Sits between front-panel inputs and the phase timer; actuator outputs go straight to the plant drivers.
// PARAMETERS
//  LOAD_W   2  width of load-size code
//  STATE_W  4  width of state encoding / state_o
//  MAX_LOAD 2  largest legal load code; larger codes clamp to MAX_LOAD when latched
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high
//  start        in   1        level; begin cycle (sampled in IDLE only)
//  abort        in   1        level; cancel active cycle
//  door_closed  in   1        1 = door shut
//  load_sel     in   LOAD_W   load size 0=small 1=medium 2=large
//  t_d,t_f,t_r,t_s,t_w in 1   timer expiry pulses: count 1, 2, 4, 8, load-dependent (2/4/8)
//  tmr_clear    out  1        holds/restarts phase timer (timer count 0 on next cycle)
//  tmr_load     out  LOAD_W   latched, clamped load code to timer
//  valve_in     out  1        inlet valve
//  valve_out    out  1        drain pump
//  agitate      out  1        wash/rinse motor
//  spin         out  1        spin motor
//  door_lock    out  1        door interlock
//  busy         out  1        cycle in progress
//  done         out  1        1-cycle pulse, cycle completed normally
//  aborted      out  1        1-cycle pulse, abort drain finished
//  state_o      out  STATE_W  current state (debug)
// BEHAVIOUR
//  Reset: state=IDLE, entry=0, tmr_load=0; all outputs 0 except tmr_clear=1. Reset mid-cycle -> same, same cycle.
//  States: IDLE, FILL, WASH, DRAIN, RFILL, RINSE, DRAIN2, SPIN, COMPLETE, ABORT_DRAIN.
//  Registered flag entry=1 on first cycle of every state; tmr_clear = entry | IDLE | COMPLETE.
//  Expiry pulses ignored while tmr_clear=1 (stale counts from previous phase).
//  IDLE: start & door_closed -> FILL; latch tmr_load = min(load_sel, MAX_LOAD). start while busy ignored.
//  Exits: FILL on t_f; WASH on t_w; DRAIN, DRAIN2, ABORT_DRAIN on t_d; RFILL on t_f; RINSE on t_r; SPIN on t_s.
//  Order: FILL->WASH->DRAIN->RFILL->RINSE->DRAIN2->SPIN->COMPLETE->IDLE (COMPLETE lasts 1 cycle, done=1).
//  Phase lengths incl. clear cycle: DRAIN 3, FILL/RFILL 4, RINSE 6, SPIN 10, WASH 4/6/10 for load 0/1/2.
//  abort | ~door_closed in any state except IDLE/COMPLETE/ABORT_DRAIN -> ABORT_DRAIN; wins over same-cycle expiry.
//  ABORT_DRAIN exit -> IDLE with aborted=1 for that exit cycle; abort/door ignored inside ABORT_DRAIN.
//  Actuators (decoded from state, no extra latency): valve_in in FILL/RFILL; agitate in WASH/RINSE;
//   valve_out in DRAIN/DRAIN2/SPIN/ABORT_DRAIN; spin in SPIN; door_lock, busy in all states but IDLE/COMPLETE.
//  Timer counter wraps at 256; no pulse lost because every exit pulse occurs within 10 cycles of clear.
// CONFIGURATION
//  EXTRA_RINSE_EN defined: 1-bit rinse_pass reg; first DRAIN2 exit -> RFILL (pass=1), second -> SPIN; adds 13 cycles.
//  Undefined: single rinse, DRAIN2 -> SPIN; no rinse_pass register.
// STRUCTURE
//  wash_pkg: state localparams, load codes (LOAD_SMALL/MED/LARGE), phase-to-expiry mapping constants.
//  Sub-module wash_act_decode: combinational state -> valve_in/valve_out/agitate/spin/door_lock/busy.
// TESTING
//  Load 0, start at cycle 0 -> FILL c1-4, WASH c5-8, DRAIN c9-11, RFILL c12-15, RINSE c16-21, DRAIN2 c22-24, SPIN c25-34, done c35.
//  Load 2 -> WASH 10 cycles, done at c41; load_sel=3 -> tmr_load=2, identical timing.
//  abort asserted in RINSE -> ABORT_DRAIN next cycle, valve_out=1, aborted pulse 3 cycles later, no done.
//  door_closed low in IDLE with start=1 -> stays IDLE, tmr_clear=1; door opens in SPIN -> ABORT_DRAIN.
//  Expiry pulse forced in entry cycle of WASH -> ignored; reset asserted in SPIN -> IDLE, outputs at reset values.
//  EXTRA_RINSE_EN: load 0 -> two RFILL/RINSE/DRAIN2 passes, done at c48.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types for the wash sequencer: state encoding, load codes and the
// mapping from each phase to the timer expiry pulse that ends it.
package wash_pkg;

  localparam int unsigned WASH_LOAD_W   = 2;
  localparam int unsigned WASH_STATE_W  = 4;
  localparam int unsigned WASH_MAX_LOAD = 2;

  typedef enum logic [WASH_STATE_W-1:0] {
    ST_IDLE        = 4'd0,
    ST_FILL        = 4'd1,
    ST_WASH        = 4'd2,
    ST_DRAIN       = 4'd3,
    ST_RFILL       = 4'd4,
    ST_RINSE       = 4'd5,
    ST_DRAIN2      = 4'd6,
    ST_SPIN        = 4'd7,
    ST_COMPLETE    = 4'd8,
    ST_ABORT_DRAIN = 4'd9
  } state_e;

  typedef enum logic [WASH_LOAD_W-1:0] {
    LOAD_SMALL = 2'd0,
    LOAD_MED   = 2'd1,
    LOAD_LARGE = 2'd2
  } load_e;

  // Which timer expiry pulse terminates a given phase
  typedef enum logic [2:0] {
    PULSE_NONE = 3'd0,
    PULSE_D    = 3'd1,
    PULSE_F    = 3'd2,
    PULSE_R    = 3'd3,
    PULSE_S    = 3'd4,
    PULSE_W    = 3'd5
  } pulse_e;

  function automatic pulse_e phase_pulse(input state_e s);
    pulse_e p;
    p = PULSE_NONE;
    case (s)
      ST_FILL, ST_RFILL:                     p = PULSE_F;
      ST_WASH:                               p = PULSE_W;
      ST_RINSE:                              p = PULSE_R;
      ST_SPIN:                               p = PULSE_S;
      ST_DRAIN, ST_DRAIN2, ST_ABORT_DRAIN:   p = PULSE_D;
      default:                               p = PULSE_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/wash_act_decode.sv
// Actuator decode: valves, motors, door lock and busy straight from the
// current state, no added latency.
module wash_act_decode
  import wash_pkg::*;
(
  input  state_e state,
  output logic   valve_in,
  output logic   valve_out,
  output logic   agitate,
  output logic   spin,
  output logic   door_lock,
  output logic   busy
);

  always_comb begin
    valve_in  = 1'b0;
    valve_out = 1'b0;
    agitate   = 1'b0;
    spin      = 1'b0;
    unique case (state)
      ST_FILL, ST_RFILL:                   valve_in  = 1'b1;
      ST_WASH, ST_RINSE:                   agitate   = 1'b1;
      ST_DRAIN, ST_DRAIN2, ST_ABORT_DRAIN: valve_out = 1'b1;
      ST_SPIN: begin
        valve_out = 1'b1;
        spin      = 1'b1;
      end
      default: ;
    endcase
    busy      = !((state == ST_IDLE) || (state == ST_COMPLETE));
    door_lock = busy;
  end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washer master sequencer: steps the wash phases off phase-timer expiry pulses.
// Optional build macro EXTRA_RINSE_EN adds a second rinse pass.
module wash_cycle_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned LOAD_W   = WASH_LOAD_W,
  parameter int unsigned STATE_W  = WASH_STATE_W,
  parameter int unsigned MAX_LOAD = WASH_MAX_LOAD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               door_closed,
  input  logic [LOAD_W-1:0]  load_sel,
  input  logic               t_d,
  input  logic               t_f,
  input  logic               t_r,
  input  logic               t_s,
  input  logic               t_w,
  output logic               tmr_clear,
  output logic [LOAD_W-1:0]  tmr_load,
  output logic               valve_in,
  output logic               valve_out,
  output logic               agitate,
  output logic               spin,
  output logic               door_lock,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [STATE_W-1:0] state_o
);

  state_e              state, state_nx, seq_next;
  logic                entry;
  logic [LOAD_W-1:0]   load_nx, load_clamp;
  logic                aborted_nx;
  logic                expired;
`ifdef EXTRA_RINSE_EN
  logic                rinse_pass, pass_nx;
`endif

  assign tmr_clear  = entry | (state == ST_IDLE) | (state == ST_COMPLETE);
  assign done       = (state == ST_COMPLETE);
  assign state_o    = STATE_W'(state);
  assign load_clamp = (load_sel > LOAD_W'(MAX_LOAD)) ? LOAD_W'(MAX_LOAD) : load_sel;

  // Expiry of the current phase; counts seen during a clear cycle are stale
  always_comb begin
    expired = 1'b0;
    unique case (phase_pulse(state))
      PULSE_D: expired = t_d;
      PULSE_F: expired = t_f;
      PULSE_R: expired = t_r;
      PULSE_S: expired = t_s;
      PULSE_W: expired = t_w;
      default: expired = 1'b0;
    endcase
    expired = expired & ~tmr_clear;
  end

  // Normal phase order
  always_comb begin
    seq_next = ST_IDLE;
    unique case (state)
      ST_FILL:   seq_next = ST_WASH;
      ST_WASH:   seq_next = ST_DRAIN;
      ST_DRAIN:  seq_next = ST_RFILL;
      ST_RFILL:  seq_next = ST_RINSE;
      ST_RINSE:  seq_next = ST_DRAIN2;
`ifdef EXTRA_RINSE_EN
      ST_DRAIN2: seq_next = rinse_pass ? ST_SPIN : ST_RFILL;
`else
      ST_DRAIN2: seq_next = ST_SPIN;
`endif
      ST_SPIN:   seq_next = ST_COMPLETE;
      default:   seq_next = ST_IDLE;
    endcase
  end

  always_comb begin
    state_nx   = state;
    load_nx    = tmr_load;
    aborted_nx = 1'b0;
`ifdef EXTRA_RINSE_EN
    pass_nx    = rinse_pass;
`endif
    unique case (state)
      ST_IDLE: begin
`ifdef EXTRA_RINSE_EN
        pass_nx = 1'b0;
`endif
        if (start && door_closed) begin
          state_nx = ST_FILL;
          load_nx  = load_clamp;
        end
      end
      ST_COMPLETE: state_nx = ST_IDLE;
      ST_ABORT_DRAIN: begin
        if (expired) begin
          state_nx   = ST_IDLE;
          aborted_nx = 1'b1;
        end
      end
      default: begin
        // Abort or open door outranks a same-cycle phase expiry
        if (abort || !door_closed) begin
          state_nx = ST_ABORT_DRAIN;
        end else if (expired) begin
          state_nx = seq_next;
`ifdef EXTRA_RINSE_EN
          if (state == ST_DRAIN2) pass_nx = ~rinse_pass;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      entry    <= 1'b0;
      tmr_load <= LOAD_W'(LOAD_SMALL);
      aborted  <= 1'b0;
    end else begin
      state    <= state_nx;
      entry    <= (state_nx != state);
      tmr_load <= load_nx;
      aborted  <= aborted_nx;
    end
  end

`ifdef EXTRA_RINSE_EN
  always_ff @(posedge clk) begin
    if (reset) rinse_pass <= 1'b0;
    else       rinse_pass <= pass_nx;
  end
`endif

  wash_act_decode u_act (
    .state     (state),
    .valve_in  (valve_in),
    .valve_out (valve_out),
    .agitate   (agitate),
    .spin      (spin),
    .door_lock (door_lock),
    .busy      (busy)
  );

endmodule
